// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the arbitration state encoding and RAM geometry.
package dmem_arb_pkg;

   localparam int RAM_AW = 6;
   localparam int DATA_W = 32;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage and a debug/loader port.
// Debug wins after MAX_WAIT denied cycles or while it holds a burst.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic              dbg_lock,
   input  logic [RAM_AW-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [RAM_AW-1:0] ram_a,
   output logic [DATA_W-1:0] ram_d,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_spo
);

   localparam logic [2:0] WAIT_LIM = 3'(MAX_WAIT);

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic [2:0]        wait_cnt_q;
   logic [2:0]        wait_cnt_d;
   logic              dbg_rvalid_q;
   logic              dbg_rvalid_d;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_d;

   logic              wait_hit;
   logic              dbg_gnt_w;
   logic              cpu_gnt_w;
   logic              unused_addr;

   assign unused_addr = ^{cpu_addr[31:8], cpu_addr[1:0]};
   assign wait_hit    = (wait_cnt_q == WAIT_LIM);

   // Grant decision; nothing is granted while reset is held.
   always_comb begin
      dbg_gnt_w = 1'b0;
      cpu_gnt_w = 1'b0;
      if (!reset) begin
         unique case (state_q)
            ARB: begin
               dbg_gnt_w = dbg_req & (~cpu_req | wait_hit);
               cpu_gnt_w = cpu_req & ~dbg_gnt_w;
            end
            BURST: begin
               dbg_gnt_w = dbg_req;
            end
            default: begin
               dbg_gnt_w = 1'b0;
            end
         endcase
      end
   end

   assign dbg_gnt   = dbg_gnt_w;
   assign cpu_stall = cpu_req & ~cpu_gnt_w & ~reset;
   assign cpu_rdata = ram_spo;

   // RAM port steering; idle cycles park the address on the CPU.
   always_comb begin
      ram_a  = cpu_addr[7:2];
      ram_d  = cpu_wdata;
      ram_we = 1'b0;
      if (dbg_gnt_w) begin
         ram_a  = dbg_addr;
         ram_d  = dbg_wdata;
         ram_we = dbg_we;
      end else if (cpu_gnt_w) begin
         ram_we = cpu_we;
      end
   end

   // Next-state: starvation counter, burst ownership, read response.
   always_comb begin
      wait_cnt_d   = 3'd0;
      state_d      = state_q;
      dbg_rvalid_d = dbg_gnt_w & ~dbg_we;
      dbg_rdata_d  = dbg_rdata_q;
      if (dbg_req && !dbg_gnt_w) begin
         wait_cnt_d = wait_hit ? wait_cnt_q : wait_cnt_q + 3'd1;
      end
      unique case (state_q)
         ARB: begin
            if (dbg_gnt_w && dbg_lock) begin
               state_d = BURST;
            end
         end
         BURST: begin
            if (!dbg_lock) begin
               state_d = ARB;
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
      if (dbg_rvalid_d) begin
         dbg_rdata_d = ram_spo;
      end
   end

   // State and registered debug response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ARB;
         wait_cnt_q   <= 3'd0;
         dbg_rvalid_q <= 1'b0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   assign dbg_rvalid = dbg_rvalid_q;
   assign dbg_rdata  = dbg_rdata_q;

endmodule
